// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory slice.
package dmem_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WIDTH single-port RAM: synchronous write, registered synchronous read, no reset.
module dmem_array #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: storage arrays carry no reset; clearing every word would turn the RAM
  // into a flop bank and the contents must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Serialised load/store responder in front of dmem_array (IDLE -> ACCESS -> RESP).
// Optional per-byte even parity with error injection when DMEM_PARITY_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] mem_out,
  output logic              rvalid,
  input  logic              rready,
  output logic              wdone,
  output logic              addr_err
`ifdef DMEM_PARITY_EN
  ,
  input  logic              inj_par,
  output logic              parity_err
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef DMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_in_range;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [MEM_W-1:0]  w_mem_wdata;
  logic [MEM_W-1:0]  w_rdata;
`ifdef DMEM_PARITY_EN
  logic              r_inj;
`endif

  // Range check on the full address; out-of-range never aliases onto a real word.
  assign w_in_range = 32'(r_addr) < 32'(DEPTH);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef DMEM_PARITY_EN
      r_inj   <= 1'b0;
`endif
    end else if (req && (r_state == IDLE)) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
`ifdef DMEM_PARITY_EN
      r_inj   <= inj_par;
`endif
    end
  end

`ifdef DMEM_PARITY_EN
  assign w_mem_wdata = {(^r_wdata) ^ r_inj, r_wdata};
`else
  assign w_mem_wdata = r_wdata;
`endif

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    w_mem_we = 1'b0;
    w_mem_re = 1'b0;
    ready    = 1'b0;
    wdone    = 1'b0;
    addr_err = 1'b0;
    rvalid   = 1'b0;
    mem_out  = '0;
`ifdef DMEM_PARITY_EN
    parity_err = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (req) w_next = ACCESS;
      end
      ACCESS: begin
        addr_err = !w_in_range;
        if (r_we) begin
          w_mem_we = w_in_range;
          wdone    = w_in_range;
          w_next   = IDLE;
        end else begin
          w_mem_re = w_in_range;
          w_next   = RESP;
        end
      end
      RESP: begin
        rvalid = 1'b1;
        if (w_in_range) begin
          mem_out = w_rdata[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
          parity_err = ^w_rdata;
`endif
        end
        if (rready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (r_addr[AW-1:0]),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver pushes expected responses, a monitor pops and compares.
module tb_dmem_responder;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        wdata = '0;
  logic              rready = 1'b0;
  logic              ready;
  logic [7:0]        mem_out;
  logic              rvalid;
  logic              wdone;
  logic              addr_err;
`ifdef DMEM_PARITY_EN
  logic              inj_par = 1'b0;
  logic              parity_err;
`endif

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .mem_out  (mem_out),
    .rvalid   (rvalid),
    .rready   (rready),
    .wdone    (wdone),
    .addr_err (addr_err)
`ifdef DMEM_PARITY_EN
    ,
    .inj_par    (inj_par),
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_store;
    logic       err;
    logic [7:0] data;
    logic       par;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_mem [DEPTH];
  logic       par_bad   [DEPTH];
  int         tests = 0;
  int         fails = 0;
  bit         chk_idle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the front of the scoreboard.
  always @(negedge clk) begin
    bit store_slot, load_slot, load_resp;
    if (!rst) begin
      if (chk_idle) begin
        check("ready_after_done", ready, 1);
        chk_idle = 1'b0;
      end
      store_slot = sb.size() > 0 && sb[0].is_store && cyc == sb[0].acc;
      load_slot  = sb.size() > 0 && !sb[0].is_store && cyc == sb[0].acc;
      load_resp  = sb.size() > 0 && !sb[0].is_store && cyc > sb[0].acc;
      if (store_slot) begin
        check("store_wdone", wdone, !sb[0].err);
        check("store_addr_err", addr_err, sb[0].err);
        void'(sb.pop_front());
        chk_idle = 1'b1;
      end else begin
        if (load_slot) begin
          check("load_addr_err", addr_err, sb[0].err);
          check("rvalid_early", rvalid, 0);
        end else if (addr_err) check("addr_err_spurious", addr_err, 0);
        if (wdone) check("wdone_spurious", wdone, 0);
      end
      if (load_resp) begin
        if (cyc == sb[0].acc + 1) check("rvalid_latency", rvalid, 1);
        if (rvalid) begin
          check("ready_in_resp", ready, 0);
          check("load_data", mem_out, sb[0].err ? 8'h00 : sb[0].data);
          if (rready) begin
`ifdef DMEM_PARITY_EN
            check("parity_err", parity_err, sb[0].par);
`endif
            void'(sb.pop_front());
            chk_idle = 1'b1;
          end
        end
      end else if (!load_slot && rvalid) check("rvalid_spurious", rvalid, 0);
      if (!rvalid) check("mem_out_zero", mem_out, 0);
    end
  end

  // Waits (bounded) for ready at posedge+1, presents one request and records its expectation.
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check("ready_timeout", ready, 1);
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic inj, input int hold);
    exp_t e;
    int   n;
    bit   in_range;
    wait_ready();
    in_range = int'(a) < DEPTH;
    req = 1'b1; we = w; addr = a; wdata = d;
`ifdef DMEM_PARITY_EN
    inj_par = inj;
`endif
    e.is_store = w;
    e.err      = !in_range;
    e.data     = (!w && in_range) ? model_mem[int'(a)] : 8'h00;
    e.par      = !w && in_range && par_bad[int'(a)];
    e.acc      = cyc + 1;
    if (w && in_range) begin
      model_mem[int'(a)] = d;
      par_bad[int'(a)]   = inj;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
`ifdef DMEM_PARITY_EN
    inj_par = 1'b0;
`endif
    if (!w) begin
      n = 0;
      while (!rvalid && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      if (!rvalid) check("rvalid_timeout", rvalid, 1);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  // Store accepted, then reset asserted during its ACCESS cycle: nothing may be written.
  task automatic reset_abort(input logic [7:0] a, input logic [7:0] d);
    wait_ready();
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    check("abort_in_access", wdone, 1);
    rst = 1'b1; req = 1'b0; we = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_wdone", wdone, 0);
    check("abort_addr_err", addr_err, 0);
    check("abort_rvalid", rvalid, 0);
    check("abort_mem_out", mem_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check("reset_ready", ready, 1);
    check("reset_rvalid", rvalid, 0);
    check("reset_wdone", wdone, 0);
    check("reset_addr_err", addr_err, 0);
    check("reset_mem_out", mem_out, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 8'(i), 8'($urandom), 1'b0, 0);

    issue(1'b1, 8'd5, 8'hA5, 1'b0, 0);
    issue(1'b0, 8'd5, 8'h00, 1'b0, 0);
    issue(1'b0, 8'd5, 8'h00, 1'b0, 4);

    issue(1'b1, 8'd8, 8'h5C, 1'b0, 0);
    issue(1'b1, 8'd40, 8'hFF, 1'b0, 0);
    issue(1'b0, 8'd40, 8'h00, 1'b0, 1);
    issue(1'b0, 8'd8, 8'h00, 1'b0, 0);

    issue(1'b1, 8'd3, 8'h11, 1'b0, 0);
    reset_abort(8'd3, 8'h22);
    issue(1'b0, 8'd3, 8'h00, 1'b0, 0);

`ifdef DMEM_PARITY_EN
    issue(1'b1, 8'd7, 8'h3C, 1'b1, 0);
    issue(1'b0, 8'd7, 8'h00, 1'b0, 0);
    issue(1'b1, 8'd7, 8'h3D, 1'b0, 0);
    issue(1'b0, 8'd7, 8'h00, 1'b0, 0);
`endif

    repeat (300) begin
      logic       w;
      logic [7:0] a;
      w = 1'($urandom);
      a = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % DEPTH);
      issue(w, a, 8'($urandom), ($urandom % 8) == 0, int'($urandom % 4));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
